// File: rtl/leading_zero.sv
// Leading-zero counter with one registered output stage.
// The count is built by a log2(N)-level tree of pairwise (valid, count)
// merges over the operand, then registered together with out_valid.
// A count of N means the operand was all zeros.
// Optional feature: define LZC_ZERO_FLAG_EN to add the registered
// 'zero' output, which flags an all-zero operand.
// N must equal 2**M, with N a power of two from 2 to 64.

module leading_zero #(
  parameter int N = 32,
  parameter int M = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] x,
  output logic         out_valid,
  output logic [M:0]   y
`ifdef LZC_ZERO_FLAG_EN
  ,
  output logic         zero
`endif
);

  // Leaves plus all merge nodes of a full binary tree over N bits.
  localparam int NODES = 2 * N - 1;

  logic         root_v;
  logic [M-1:0] root_c;
  logic [M:0]   y_next;

  // Pairwise merge tree, laid out level by level.
  // Level l has N>>l nodes and starts at index 2N - (2N>>l).
  // Within a level, node j covers the bits below node j+1.
  // Each node holds a flag that some bit in its span is set, and the
  // number of leading zeros in that span, which is meaningful only while
  // the flag is set. When the upper half has no set bit, the result is
  // the lower half's count plus the upper half's width. That width is a
  // power of two that the lower count never reaches, so the add is an OR.
  always_comb begin
    logic         v [NODES];
    logic [M-1:0] c [NODES];
    int           prev_off;
    int           cur_off;
    logic [M-1:0] half;

    for (int i = 0; i < NODES; i++) begin
      v[i] = 1'b0;
      c[i] = '0;
    end
    prev_off = 0;
    cur_off  = 0;
    half     = '0;

    for (int i = 0; i < N; i++) begin
      v[i] = x[i];
      c[i] = '0;
    end

    for (int l = 1; l <= M; l++) begin
      prev_off = 2 * N - ((2 * N) >> (l - 1));
      cur_off  = 2 * N - ((2 * N) >> l);
      half     = M'(1) << (l - 1);
      for (int j = 0; j < (N >> l); j++) begin
        v[cur_off + j] = v[prev_off + 2 * j + 1] | v[prev_off + 2 * j];
        c[cur_off + j] = v[prev_off + 2 * j + 1] ? c[prev_off + 2 * j + 1]
                                                 : (c[prev_off + 2 * j] | half);
      end
    end

    root_v = v[NODES - 1];
    root_c = c[NODES - 1];
  end

  // An empty operand maps to N, which is the MSB of y alone.
  always_comb begin
    y_next = root_v ? {1'b0, root_c} : {1'b1, {M{1'b0}}};
  end

  // Output register. Reset has priority over an incoming operand.
  // On an idle cycle the result holds and only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
`ifdef LZC_ZERO_FLAG_EN
      zero      <= 1'b0;
`endif
    end else if (in_valid) begin
      out_valid <= 1'b1;
      y         <= y_next;
`ifdef LZC_ZERO_FLAG_EN
      zero      <= ~root_v;
`endif
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leading_zero.sv
// Scoreboard bench for leading_zero at the default width of 32.
// Each accepted operand pushes its expected count onto a queue.
// A monitor pops one entry and compares it on every cycle where out_valid is high.
`timescale 1ns/1ps

module tb_leading_zero;

  localparam int N = 32;
  localparam int M = 5;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] x;
  logic         out_valid;
  logic [M:0]   y;
`ifdef LZC_ZERO_FLAG_EN
  logic         zero;
`endif

  int errors = 0;
  int checks = 0;

  // Expected entry: {zero flag, count}.
  logic [M+1:0] exp_q [$];

  leading_zero #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .out_valid (out_valid),
    .y         (y)
`ifdef LZC_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand at the falling edge and record its expected count.
  task automatic send(input logic [N-1:0] val, input int exp_y);
    logic [M:0] ey;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    x        = val;
    ey       = (M+1)'(exp_y);
    exp_q.push_back({(val == '0), ey});
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [M:0] act, input logic [M:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: one queued expectation is consumed per valid output.
  initial begin
    logic [M+1:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: out_valid=1 y=%0d with no pending operand", y);
        end else begin
          e = exp_q.pop_front();
          if (y !== e[M:0]) begin
            errors++;
            $display("FAIL lzc_y: got %0d, expected %0d", y, e[M:0]);
          end
`ifdef LZC_ZERO_FLAG_EN
          checks++;
          if (zero !== e[M+1]) begin
            errors++;
            $display("FAIL lzc_zero: got %0b, expected %0b", zero, e[M+1]);
          end
`endif
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    x        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {{M{1'b0}}, out_valid}, '0);
    check("reset_y", y, '0);

    // First operand right after reset: all zeros counts as N.
    send(32'h0000_0000, 32);
    send(32'hFFFF_FFFF, 0);
    send(32'h8000_0000, 0);

    // Back-to-back operands, then an idle gap after the result 24.
    send(32'h0000_8000, 16);
    send(32'h0000_0001, 31);
    send(32'h0000_00FF, 24);
    idle();
    repeat (3) begin
      @(negedge clk);
      check("hold_out_valid", {{M{1'b0}}, out_valid}, '0);
      check("hold_y", y, 6'd24);
    end

    send(32'h0000_3FFF, 18);
    send(32'h000F_FFFF, 12);
    send(32'h4000_0000, 1);
    send(32'h0000_0002, 30);

    // Walking one from bit 0 to bit 31.
    for (int i = 0; i < N; i++) begin
      send(32'h0000_0001 << i, 31 - i);
    end

    // Reset arrives together with a valid operand, and the operand is dropped.
    send(32'h0001_0000, 15);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    x        = 32'h0000_0001;
    @(negedge clk);
    check("rst_drop_out_valid", {{M{1'b0}}, out_valid}, '0);
    check("rst_drop_y", y, '0);
    rst      = 1'b0;
    in_valid = 1'b0;

    send(32'h000F_FFFF, 12);
    send(32'h0000_0000, 32);
    idle();
    repeat (2) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/leading_zero.md
LEADING_ZERO -- requirements
Module: leading_zero

Interface
REQ-001 Parameter N, default 32, meaning input word width in bits; legal values are powers of two from 2 to 64, and N SHALL equal 2^M.
REQ-002 Parameter M, default 5, meaning log2(N); the count output is M+1 bits wide so that it can represent the value N.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  marks x as a valid operand in this cycle.
REQ-006 x  input  N  operand; bit N-1 is the MSB.
REQ-007 out_valid  output  1  y holds a result for an operand accepted one cycle earlier.
REQ-008 y  output  M+1  number of leading zeros of the accepted x.
REQ-009 zero  output  1  high when the accepted x was all zeros; present only when LZC_ZERO_FLAG_EN is defined (see REQ-021).

Function
REQ-010 y SHALL equal the count of consecutive 0 bits in x, starting at bit N-1 and moving toward bit 0, stopped by the first 1 bit.
REQ-011 For x == 0, y SHALL equal N (32 at the default width), encoded with the MSB of y set and all lower bits clear.
REQ-012 For x with bit N-1 set, y SHALL equal 0.
REQ-013 Latency SHALL be exactly 1 cycle: when in_valid=1 at rising edge k, y and out_valid=1 are valid after edge k.
REQ-014 When in_valid=0 at an edge, out_valid SHALL go 0 and y (and zero, if present) SHALL hold their previous values.
REQ-015 Back-to-back operands SHALL be accepted every cycle with no stall; there is no ready/backpressure signal.
REQ-016 Counting SHALL be implemented as a combinational log2(N)-level tree of pairwise (valid, count) merges followed by one output register stage; a linear priority chain is not acceptable.
REQ-017 y SHALL never exceed N; values N+1 and above are illegal.

Reset
REQ-018 While rst=1 at a rising edge: out_valid<=0, y<=0, zero<=0 (if present); in_valid is ignored.
REQ-019 If rst and in_valid are both high at an edge, reset wins and the operand is dropped.
REQ-020 On the first edge with rst=0 and in_valid=1, normal 1-cycle operation resumes with no warm-up.

Configuration
REQ-021 Macro LZC_ZERO_FLAG_EN: when defined, the port zero exists and is registered alongside y, set to 1 exactly when the accepted x == 0; when undefined, the port zero and its register are absent, and y/out_valid behaviour is unchanged.

Verification
REQ-022 x=32'h0000_0000 with in_valid=1 -> next cycle y=32, out_valid=1, zero=1 (with macro).
REQ-023 x=32'hFFFF_FFFF, then 32'h8000_0000 -> y=0 for both, zero=0.
REQ-024 Back-to-back x=32'h0000_8000, 32'h0000_0001, 32'h0000_00FF, 32'h0000_3FFF, 32'h000F_FFFF -> y=16, 31, 24, 18, 12 on consecutive cycles.
REQ-025 Walking-one sweep: x=1<<i for i=0..31 -> y=31-i each cycle.
REQ-026 Assert rst mid-stream together with in_valid=1 and x=32'h0000_0001 -> next cycle out_valid=0, y=0; deassert rst -> next operand result appears after 1 cycle.
REQ-027 Hold in_valid=0 after a result y=24 -> y stays 24 and out_valid=0.
